// File: rtl/fwrisc_mem_pkg.sv
// Shared constants, region/state/winner types and address decode for the fwrisc memory arbiter.
package fwrisc_mem_pkg;

  localparam logic [31:0] ROM_BASE    = 32'h8000_0000;
  localparam logic [31:0] RAM_BASE    = 32'h8001_0000;
  localparam logic [31:0] UART_BASE   = 32'h8002_0000;
  localparam logic [31:0] REGION_MASK = 32'hFFFF_0000;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, MEM, RESP, PERIPH} state_e;
  typedef enum logic [1:0] {W_NONE, W_LD, W_D, W_I} winner_e;
  typedef enum logic [1:0] {R_ROM, R_RAM, R_UART, R_NONE} region_e;

  function automatic region_e decode_region(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & REGION_MASK;
    if (base == ROM_BASE)       return R_ROM;
    else if (base == RAM_BASE)  return R_RAM;
    else if (base == UART_BASE) return R_UART;
    else                        return R_NONE;
  endfunction

endpackage

// File: rtl/fwrisc_mem_arbiter_if.sv
// Bus bundle between the arbiter (slave view) and the core, loader, memory and UART (master view).
interface fwrisc_mem_arbiter_if #(
  parameter int MEM_AW = 13
);
  logic [31:0]       iaddr;
  logic              ivalid;
  logic              iready;
  logic [31:0]       idata;

  logic [31:0]       daddr;
  logic [31:0]       dwdata;
  logic [3:0]        dstrb;
  logic              dwrite;
  logic              dvalid;
  logic              dready;
  logic [31:0]       drdata;

  logic [11:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              ld_valid;
  logic              ld_ready;

  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_strb;
  logic [31:0]       mem_rdata;

  logic              p_valid;
  logic [31:0]       p_addr;
  logic [31:0]       p_wdata;
  logic [3:0]        p_strb;
  logic              p_write;
  logic              p_ready;
  logic [31:0]       p_rdata;

  logic              bus_err_o;

  modport slave (
    input  iaddr, ivalid, daddr, dwdata, dstrb, dwrite, dvalid,
           ld_addr, ld_data, ld_valid, mem_rdata, p_ready, p_rdata,
    output iready, idata, dready, drdata, ld_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
           p_valid, p_addr, p_wdata, p_strb, p_write, bus_err_o
  );

  modport master (
    output iaddr, ivalid, daddr, dwdata, dstrb, dwrite, dvalid,
           ld_addr, ld_data, ld_valid, mem_rdata, p_ready, p_rdata,
    input  iready, idata, dready, drdata, ld_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
           p_valid, p_addr, p_wdata, p_strb, p_write, bus_err_o
  );
endinterface

// File: rtl/fwrisc_mem_arb_prio.sv
// Requester priority: loader before boot, then data over instruction with a starvation
// counter that forces one instruction grant after STARVE_MAX back-to-back data grants.
module fwrisc_mem_arb_prio
  import fwrisc_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    grant_en,
  input  logic    boot_done_i,
  input  logic    ld_valid,
  input  logic    dvalid,
  input  logic    ivalid,
  output winner_e winner
);
  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved = (starve_q == 4'(STARVE_MAX));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner = W_NONE;
    if (!boot_done_i) begin
      if (ld_valid) winner = W_LD;
    end else if (ivalid && (!dvalid || starved)) begin
      winner = W_I;
    end else if (dvalid) begin
      winner = W_D;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ivalid)                          starve_d = '0;
    else if (grant_en && winner == W_I)   starve_d = '0;
    else if (grant_en && winner == W_D)   starve_d = starve_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Shares the ROM/RAM port between UART loader, core data and core fetch; routes UART-region
// data accesses to the peripheral port. `define FWRISC_MEM_ARB_PTIMEOUT_EN adds a peripheral timeout.
module fwrisc_mem_arbiter
  import fwrisc_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int MEM_AW     = 13,
  parameter int PTIMEOUT   = 255
) (
  input logic                  clock,
  input logic                  reset,
  input logic                  boot_done_i,
  fwrisc_mem_arbiter_if.slave  bus
);
  state_e            state_q, state_d;
  winner_e           winner_q, winner_d, win;
  logic              rd_mem_q, rd_mem_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_strb_q, mem_strb_d;
  logic              iready_q, iready_d, dready_q, dready_d, ld_ready_q, ld_ready_d;
  logic              bus_err_q, bus_err_d;
  logic              p_valid_q, p_valid_d, p_write_q, p_write_d;
  logic [31:0]       p_addr_q, p_addr_d, p_wdata_q, p_wdata_d;
  logic [3:0]        p_strb_q, p_strb_d;
  logic              p_hit;
  region_e           dreg, ireg;
  logic              unused_iaddr;
`ifdef FWRISC_MEM_ARB_PTIMEOUT_EN
  localparam int PT_W = $clog2(PTIMEOUT + 1);
  logic [PT_W-1:0]   ptime_q, ptime_d;
  logic              dead_q, dead_d;
`endif

  fwrisc_mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clock       (clock),
    .reset       (reset),
    .grant_en    (state_q == IDLE),
    .boot_done_i (boot_done_i),
    .ld_valid    (bus.ld_valid),
    .dvalid      (bus.dvalid),
    .ivalid      (bus.ivalid),
    .winner      (win)
  );

  assign dreg         = decode_region(bus.daddr);
  assign ireg         = decode_region(bus.iaddr);
  assign unused_iaddr = ^{bus.iaddr[15:14], bus.iaddr[1:0]};

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rd_mem_d    = rd_mem_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_strb_d  = '0;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    ld_ready_d  = 1'b0;
    bus_err_d   = 1'b0;
    p_valid_d   = p_valid_q;
    p_addr_d    = p_addr_q;
    p_wdata_d   = p_wdata_q;
    p_strb_d    = p_strb_q;
    p_write_d   = p_write_q;
`ifdef FWRISC_MEM_ARB_PTIMEOUT_EN
    ptime_d     = ptime_q;
    dead_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        winner_d = win;
        rd_mem_d = 1'b0;
        unique case (win)
          W_LD: begin
            state_d     = MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = MEM_AW'(bus.ld_addr);
            mem_wdata_d = bus.ld_data;
            mem_strb_d  = 4'hF;
          end
          W_I: begin
            if (ireg == R_ROM || ireg == R_RAM) begin
              state_d    = MEM;
              mem_req_d  = 1'b1;
              mem_addr_d = {ireg == R_RAM, bus.iaddr[MEM_AW:2]};
              mem_strb_d = 4'hF;
              rd_mem_d   = 1'b1;
            end else begin
              state_d   = RESP;
              iready_d  = 1'b1;
              bus_err_d = 1'b1;
            end
          end
          W_D: begin
            if (dreg == R_UART) begin
              state_d   = PERIPH;
              p_valid_d = 1'b1;
              p_addr_d  = bus.daddr;
              p_wdata_d = bus.dwdata;
              p_strb_d  = bus.dstrb;
              p_write_d = bus.dwrite;
`ifdef FWRISC_MEM_ARB_PTIMEOUT_EN
              ptime_d   = '0;
`endif
            end else if (dreg == R_RAM || (dreg == R_ROM && !bus.dwrite)) begin
              state_d     = MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = bus.dwrite;
              mem_addr_d  = {dreg == R_RAM, bus.daddr[MEM_AW:2]};
              mem_wdata_d = bus.dwdata;
              mem_strb_d  = bus.dstrb;
              rd_mem_d    = !bus.dwrite;
            end else begin
              // ROM writes are dropped and unmapped addresses answered with zero, both flagged.
              state_d   = RESP;
              dready_d  = 1'b1;
              bus_err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      MEM: begin
        state_d = RESP;
        unique case (winner_q)
          W_LD:    ld_ready_d = 1'b1;
          W_I:     iready_d   = 1'b1;
          W_D:     dready_d   = 1'b1;
          default: ;
        endcase
      end
      RESP: begin
        state_d  = IDLE;
        winner_d = W_NONE;
        rd_mem_d = 1'b0;
      end
      PERIPH: begin
        if (bus.p_ready) begin
          state_d   = IDLE;
          winner_d  = W_NONE;
          p_valid_d = 1'b0;
          p_addr_d  = '0;
          p_wdata_d = '0;
          p_strb_d  = '0;
          p_write_d = 1'b0;
`ifdef FWRISC_MEM_ARB_PTIMEOUT_EN
        end else if (ptime_q == PT_W'(PTIMEOUT - 1)) begin
          state_d   = RESP;
          dready_d  = 1'b1;
          bus_err_d = 1'b1;
          dead_d    = 1'b1;
          p_valid_d = 1'b0;
          p_addr_d  = '0;
          p_wdata_d = '0;
          p_strb_d  = '0;
          p_write_d = 1'b0;
        end else begin
          ptime_d = ptime_q + PT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      winner_q    <= W_NONE;
      rd_mem_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      ld_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      p_valid_q   <= 1'b0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      p_strb_q    <= '0;
      p_write_q   <= 1'b0;
`ifdef FWRISC_MEM_ARB_PTIMEOUT_EN
      ptime_q     <= '0;
      dead_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rd_mem_q    <= rd_mem_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
      ld_ready_q  <= ld_ready_d;
      bus_err_q   <= bus_err_d;
      p_valid_q   <= p_valid_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      p_strb_q    <= p_strb_d;
      p_write_q   <= p_write_d;
`ifdef FWRISC_MEM_ARB_PTIMEOUT_EN
      ptime_q     <= ptime_d;
      dead_q      <= dead_d;
`endif
    end
  end

  // Peripheral responses pass straight through so dready lines up with p_ready.
  assign p_hit = (state_q == PERIPH) && bus.p_ready;

  always_comb begin
    bus.drdata = '0;
    if (dready_q) begin
      if (rd_mem_q) bus.drdata = bus.mem_rdata;
`ifdef FWRISC_MEM_ARB_PTIMEOUT_EN
      else if (dead_q) bus.drdata = ERR_DATA;
`endif
    end else if (p_hit) begin
      bus.drdata = bus.p_rdata;
    end
  end

  assign bus.idata     = (iready_q && rd_mem_q) ? bus.mem_rdata : '0;
  assign bus.iready    = iready_q;
  assign bus.dready    = dready_q | p_hit;
  assign bus.ld_ready  = ld_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_strb  = mem_strb_q;
  assign bus.p_valid   = p_valid_q;
  assign bus.p_addr    = p_addr_q;
  assign bus.p_wdata   = p_wdata_q;
  assign bus.p_strb    = p_strb_q;
  assign bus.p_write   = p_write_q;
  assign bus.bus_err_o = bus_err_q;
endmodule
